// File: rtl/usb_fifo_pkg.sv
// Shared types and helpers for the USB FIFO read/write schedulers.
package usb_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  // Width of a round-robin index; never narrower than one bit.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_fifo_read_sched_if.sv
// Consumer-side and FIFO-side signals of the read scheduler, bundled for port passing.
interface usb_fifo_read_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic                         flush;
  logic                         fifo_empty;
  logic [DATA_WIDTH-1:0]        fifo_rdata;
  logic                         fifo_read_enable;
  logic                         fifo_clear;
  logic [NUM_REQ-1:0]           grant;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_valid;
  logic                         out_last;
  logic                         out_ready;
  logic                         timeout_err;

  modport master (
    input  req, req_len, flush, fifo_empty, fifo_rdata, out_ready,
    output fifo_read_enable, fifo_clear, grant, out_data, out_valid, out_last, timeout_err
  );

  modport slave (
    output req, req_len, flush, fifo_empty, fifo_rdata, out_ready,
    input  fifo_read_enable, fifo_clear, grant, out_data, out_valid, out_last, timeout_err
  );
endinterface

// File: rtl/usb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module usb_rr_arbiter
  import usb_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = rr_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any        = 1'b1;
        idx        = IDX_W'(cand);
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_fifo_read_sched.sv
// Round-robin read-port scheduler for the USB host async FIFO (read_clk domain).
// Define USB_FIFO_RD_TIMEOUT_EN to abort bursts starved by an empty FIFO for TIMEOUT_CYC cycles.
module usb_fifo_read_sched
  import usb_fifo_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  usb_fifo_read_sched_if.master bus
);

  localparam int IDX_W = rr_idx_w(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || DATA_WIDTH < 1) begin : g_bad_params
    $error("usb_fifo_read_sched: unsupported parameter set");
  end

  sched_state_t         state, state_nxt;
  logic [NUM_REQ-1:0]   grant, grant_nxt;
  logic [IDX_W-1:0]     gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [LEN_WIDTH-1:0] count, count_nxt;
  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 beat_valid;
  logic                 handshake;
  logic                 timeout_hit;

  usb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // flush suppresses the beat outright so a pending pop is never issued alongside a clear
  assign beat_valid           = (state == XFER) && !bus.fifo_empty && !bus.flush;
  assign handshake            = beat_valid && bus.out_ready;
  assign bus.out_valid        = beat_valid;
  assign bus.fifo_read_enable = handshake;
  assign bus.out_last         = beat_valid && (count == '0);
  assign bus.out_data         = bus.fifo_rdata;
  assign bus.fifo_clear       = (state == FLUSH);
  assign bus.grant            = grant;
  assign bus.timeout_err      = timeout_hit;

`ifdef USB_FIFO_RD_TIMEOUT_EN
  localparam int STARVE_W = $clog2(TIMEOUT_CYC) + 1;
  logic [STARVE_W-1:0] starve;

  assign timeout_hit = (state == XFER) && bus.fifo_empty && !bus.flush &&
                       (starve == STARVE_W'(TIMEOUT_CYC - 1));

  // Counts consecutive empty XFER cycles; any data-available cycle restarts it.
  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst)                                         starve <= '0;
    else if (state != XFER || !bus.fifo_empty || timeout_hit) starve <= '0;
    else                                                   starve <= starve + STARVE_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge read_clk or negedge read_rst) begin
    if (!read_rst) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    count_nxt   = count;
    case (state)
      IDLE: begin
        if (bus.flush) begin
          state_nxt = FLUSH;
        end else if (pick_any) begin
          state_nxt   = XFER;
          grant_nxt   = pick;
          gnt_idx_nxt = pick_idx;
          count_nxt   = bus.req_len[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];
        end
      end
      XFER: begin
        // Aborted bursts leave rr_ptr alone so the same consumer is offered first again.
        if (bus.flush) begin
          state_nxt = FLUSH;
          grant_nxt = '0;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (handshake) begin
          if (count == '0) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          end else begin
            count_nxt = count - LEN_WIDTH'(1);
          end
        end
      end
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/usb_fifo_read_sched.md
Name: usb_fifo_read_sched

Overview:
Read-side scheduler for the USB host controller's async AXI FIFO. It shares the FIFO's single read port between NUM_REQ consumers (e.g. bulk, interrupt, control and ISO packet builders) using round-robin arbitration. It grants one consumer at a time for a committed burst of beats and drives the FIFO read_enable. It also sequences FIFO clear on flush. The block lives entirely in the read_clk domain, next to the FIFO read-pointer logic.

Parameters:
NUM_REQ, 4, number of requesting consumers (2..8)
DATA_WIDTH, 32, FIFO read-data width
LEN_WIDTH, 8, burst-length field width; value encodes beats-1
TIMEOUT_CYC, 1024, starvation limit in cycles (used only with the optional feature)

Ports:
read_clk  in  1  read-domain clock
read_rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-consumer burst request (level)
req_len  in  NUM_REQ*LEN_WIDTH  per-consumer beats-1; slice i belongs to req[i]
flush  in  1  abort current burst and clear FIFO
fifo_empty  in  1  FIFO empty flag (registered in FIFO)
fifo_rdata  in  DATA_WIDTH  FIFO data at current read address, valid when !fifo_empty
fifo_read_enable  out  1  FIFO pop
fifo_clear  out  1  one-cycle synchronous clear to FIFO read pointer
grant  out  NUM_REQ  one-hot grant, held for the whole burst
out_data  out  DATA_WIDTH  shared data to the granted consumer
out_valid  out  1  beat valid
out_last  out  1  final beat of the burst
out_ready  in  1  granted consumer accepts beat
timeout_err  out  1  one-cycle pulse (optional feature only)

Behaviour:
- Reset (read_rst low, async): state IDLE; grant=0; rr pointer=0; beat counter=0; fifo_clear=0; timeout_err=0. Outputs fifo_read_enable, out_valid and out_last evaluate to 0.
- States: IDLE, XFER, FLUSH.
- IDLE:
  - If flush: go to FLUSH.
  - Else if any req: pick the first set req starting at index (rr_ptr) and wrapping modulo NUM_REQ.
  - Register its one-hot grant and load count = req_len slice. Go to XFER the next cycle.
  - Grant appears 1 cycle after req is sampled.
- XFER:
  - out_valid = !fifo_empty & !flush.
  - out_data = fifo_rdata, combinational passthrough.
  - fifo_read_enable = out_valid & out_ready.
  - out_last = out_valid & (count==0).
  - On each handshake, decrement count.
  - Handshake with count==0: clear grant, set rr_ptr = granted index+1 (wrapping to 0 after NUM_REQ-1), go to IDLE. This leaves a 1-cycle bubble between bursts.
- Committed bursts: deasserting req or changing req_len during XFER is ignored.
- FIFO empty mid-burst: stall with out_valid=0. The count is held; no pop is issued.
- flush in XFER, including the same cycle as the last handshake: flush wins.
  - Gate fifo_read_enable off; the beat is not consumed.
  - Clear grant; rr_ptr does not advance; go to FLUSH.
- FLUSH: fifo_clear=1 for exactly one cycle, then IDLE. A flush held high re-enters FLUSH from IDLE, pulsing every other cycle.
- Width rules:
  - Burst length 1..2^LEN_WIDTH beats; count is LEN_WIDTH bits, no zero-length bursts.
  - rr_ptr is clog2(NUM_REQ) bits with explicit wrap at NUM_REQ-1.

Optional Feature:
USB_FIFO_RD_TIMEOUT_EN:
- Defined:
  - A clog2(TIMEOUT_CYC)+1-bit starvation counter counts consecutive XFER cycles with fifo_empty=1. It resets on any handshake and on entering XFER.
  - On reaching TIMEOUT_CYC: pulse timeout_err for 1 cycle, clear grant, do not advance rr_ptr, go to IDLE. The FIFO is not cleared.
- Undefined: no counter logic; timeout_err is tied to 0, and XFER stalls indefinitely on empty.

Decomposition:
- Package usb_fifo_pkg:
  - state encoding (IDLE=2'd0, XFER=2'd1, FLUSH=2'd2)
  - default LEN_WIDTH and DATA_WIDTH constants
  - rr-index width function
- Sub-module usb_rr_arbiter: combinational round-robin picker with inputs req and rr_ptr, outputs one-hot pick and index. It is reusable for the write-side scheduler.

Test Plan:
- req=4'b0001, len=3, FIFO holding 4 words, out_ready=1 -> grant=0001 one cycle later; 4 consecutive pops; out_last on the 4th; grant drops; rr_ptr=1.
- req=4'b1111 held, each len=0 -> grants in order 0001, 0010, 0100, 1000, 0001, each one beat, with a 1-cycle bubble between grants.
- Burst len=7, FIFO empties after 3 beats for 5 cycles -> out_valid=0 and no fifo_read_enable during the gap; remaining 5 beats delivered; out_last on beat 8.
- flush asserted together with the final handshake of req[2] -> no pop that cycle; fifo_clear pulses once next cycle; the next grant still starts from index 2.
- read_rst low mid-XFER (beat 2 of 6) -> grant=0, fifo_read_enable=0 immediately; after release, IDLE with rr_ptr=0.
- USB_FIFO_RD_TIMEOUT_EN, TIMEOUT_CYC=16, grant with FIFO permanently empty -> timeout_err pulse exactly at the 16th empty cycle, grant cleared, no fifo_clear.
